note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Plays a melody stored in an external note table, one entry per note, and drives the sine-path clock generator and tone gating.
- Fetches each entry (pitch divider, duration) over a req/ack handshake.
- Counts the note duration on a sample-rate tick and inserts an articulation gap at the end of each note.
- Replaces the hard-coded melody/duration arrays in the top level. Supports start/stop, loop or one-shot play, rests, and an end-of-song marker.

Parameters:
- PITCH_W, 5, width of pitch divider (clkgen maxval) field
- DUR_W, 13, width of duration field, in ticks
- ADDR_W, 5, note table address width
- SONG_LEN, 20, number of table entries; index SONG_LEN-1 is the last note
- GAP_TICKS, 1, silent ticks at the end of each note

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  duration time base, one clk wide (e.g. fs strobe)
- start  in  1  start-play pulse
- stop  in  1  stop-play pulse
- loop_en  in  1  1 = restart at index 0 after the last note; sampled at end of song
- rom_req  out  1  fetch request
- rom_addr  out  ADDR_W  note index being fetched
- rom_ack  in  1  fetch data valid
- rom_pitch  in  PITCH_W  divider value; 0 = rest
- rom_dur  in  DUR_W  duration in ticks; 0 = end-of-song marker
- pitch_maxval  out  PITCH_W  divider for the sine clkgen
- pitch_load  out  1  one-cycle pulse when pitch_maxval is updated (clkgen restart)
- tone_en  out  1  1 = sine output audible
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on one-shot completion
- note_idx  out  ADDR_W  index of the current note

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0: rom_req, rom_addr, pitch_maxval, pitch_load, tone_en, busy, done, note_idx. Internal remaining-tick counter 0. Reset mid-play aborts immediately; the next play requires a new start.
- States: IDLE, FETCH, PLAY, END.
- IDLE:
  - start=1 -> FETCH next cycle, with rom_addr=0, note_idx=0, rom_req=1, busy=1.
  - Latency: start at cycle N -> rom_req=1 at N+1.
- FETCH:
  - rom_req stays 1 and rom_addr stays stable until rom_ack is sampled high. An ack in the first request cycle is legal. Data is sampled in the ack cycle. tone_en=0 throughout FETCH.
  - On ack with rom_dur==0 -> END.
  - On any other ack -> PLAY at ack+1. At that cycle: rom_req=0, pitch_maxval=rom_pitch, pitch_load=1 for exactly one cycle, remaining=rom_dur.
  - tone_en at ack+1 = (rom_pitch!=0) AND (rom_dur>GAP_TICKS).
- PLAY:
  - Each tick decrements remaining by 1; no tick means no change. remaining is DUR_W wide and never underflows.
  - When remaining becomes GAP_TICKS, tone_en goes to 0 the cycle after that tick.
  - On the tick where remaining==1 (the last tick of the note):
    - If note_idx==SONG_LEN-1 -> END.
    - Otherwise -> FETCH with rom_addr=note_idx+1. note_idx updates together with rom_addr. rom_req=1 the cycle after that tick.
- END (one cycle):
  - loop_en=1 -> FETCH with rom_addr=0.
  - loop_en=0 -> IDLE: done=1 for one cycle, busy=0, tone_en=0.
- stop=1 in any state:
  - -> IDLE next cycle: rom_req=0, tone_en=0, busy=0, no done pulse.
  - stop has priority over start, rom_ack and tick in the same cycle.
  - An outstanding ack after stop is ignored.
- start while busy is ignored.
- pitch_maxval keeps its last value in IDLE; tone_en alone gates the output.
- Rest entry (pitch 0): timing is identical to a note, tone_en stays 0, and pitch_load still pulses.
- A duration of 1..GAP_TICKS gives a note that is fully silent but still timed.
- ADDR_W must hold SONG_LEN-1. The index never exceeds SONG_LEN-1 and wraps only via END.

Test Plan:
- One-shot, SONG_LEN=3, GAP_TICKS=1, table {(18,4),(13,2),(0,3)}, ack 2 cycles after req, loop_en=0:
  - pitch_load pulses with 18, then 13, then 0.
  - tone_en is high for 3 ticks, then for 1 tick, then stays 0 for the rest note.
  - done pulses once after the 3rd tick of entry 2; busy=0 afterwards.
- Loop: same table, loop_en=1 -> after the entry-2 last tick, rom_addr=0 is requested and pitch 18 reloads; done never pulses.
- End marker: table {(20,2),(x,0)} -> after 2 ticks, entry 1 is fetched, done pulses, entry 2 is never requested.
- Stop mid-note, on the same cycle as tick -> IDLE next cycle, tone_en=0, rom_req=0, no done; a new start fetches rom_addr=0.
- Ack held off for 50 cycles with ticks arriving -> rom_addr stable, tone_en=0, no ticks consumed; the note then plays its full duration.
- Async reset asserted mid-PLAY, between clock edges -> all outputs 0 immediately. start after release behaves as in the first scenario.

Source files
------------

// File: rtl/note_sequencer.sv
// Note-table melody sequencer: fetches (pitch, duration) entries over a req/ack
// handshake, times each note on a sample tick and drives clkgen reload and tone gating.
module note_sequencer #(
  parameter int PITCH_W   = 5,
  parameter int DUR_W     = 13,
  parameter int ADDR_W    = 5,
  parameter int SONG_LEN  = 20,
  parameter int GAP_TICKS = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  output logic               rom_req,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic               rom_ack,
  input  logic [PITCH_W-1:0] rom_pitch,
  input  logic [DUR_W-1:0]   rom_dur,
  output logic [PITCH_W-1:0] pitch_maxval,
  output logic               pitch_load,
  output logic               tone_en,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  note_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SONG_LEN - 1);
  localparam logic [DUR_W-1:0]  GAP      = DUR_W'(GAP_TICKS);
  localparam logic [DUR_W-1:0]  ONE      = DUR_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2,
    ENDS  = 2'd3
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_idx;
  logic [DUR_W-1:0]   r_remaining;
  logic [PITCH_W-1:0] r_pitch;
  logic               r_load;
  logic               r_tone;
  logic               r_req;
  logic               r_busy;
  logic               r_done;
  logic [DUR_W-1:0]   w_remNext;

  assign w_remNext = r_remaining - ONE;

  // The fetch address and the current note index always move together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_remaining <= '0;
      r_pitch     <= '0;
      r_load      <= 1'b0;
      r_tone      <= 1'b0;
      r_req       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_load <= 1'b0;
      r_done <= 1'b0;
      if (stop) begin
        r_state <= IDLE;
        r_req   <= 1'b0;
        r_tone  <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_state <= FETCH;
              r_idx   <= '0;
              r_req   <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
          FETCH: begin
            r_tone <= 1'b0;
            if (rom_ack) begin
              r_req <= 1'b0;
              if (rom_dur == '0) begin
                r_state <= ENDS;
              end else begin
                r_state     <= PLAY;
                r_pitch     <= rom_pitch;
                r_load      <= 1'b1;
                r_remaining <= rom_dur;
                r_tone      <= (rom_pitch != '0) && (rom_dur > GAP);
              end
            end
          end
          PLAY: begin
            if (tick) begin
              if (r_remaining == ONE) begin
                r_remaining <= '0;
                r_tone      <= 1'b0;
                if (r_idx == LAST_IDX) begin
                  r_state <= ENDS;
                end else begin
                  r_state <= FETCH;
                  r_idx   <= r_idx + ADDR_W'(1);
                  r_req   <= 1'b1;
                end
              end else begin
                r_remaining <= w_remNext;
                if (w_remNext <= GAP) begin
                  r_tone <= 1'b0;
                end
              end
            end
          end
          ENDS: begin
            if (loop_en) begin
              r_state <= FETCH;
              r_idx   <= '0;
              r_req   <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_tone  <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_tone  <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rom_req      = r_req;
  assign rom_addr     = r_idx;
  assign note_idx     = r_idx;
  assign pitch_maxval = r_pitch;
  assign pitch_load   = r_load;
  assign tone_en      = r_tone;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a 3-entry song and a one-tick articulation gap.
module tb_note_sequencer;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic       rom_req;
  logic [4:0] rom_addr;
  logic       rom_ack;
  logic [4:0] rom_pitch;
  logic [12:0] rom_dur;
  logic [4:0] pitch_maxval;
  logic       pitch_load;
  logic       tone_en;
  logic       busy;
  logic       done;
  logic [4:0] note_idx;

  int compared;
  int mismatched;
  int doneCount;

  note_sequencer #(
    .PITCH_W(5), .DUR_W(13), .ADDR_W(5), .SONG_LEN(3), .GAP_TICKS(1)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
    .loop_en(loop_en), .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
    .rom_pitch(rom_pitch), .rom_dur(rom_dur), .pitch_maxval(pitch_maxval),
    .pitch_load(pitch_load), .tone_en(tone_en), .busy(busy), .done(done),
    .note_idx(note_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) doneCount++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doTick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // Holds the request for 'delay' cycles, then acks with the given entry.
  task automatic serveFetch(input logic [4:0] addr, input int delay,
                            input logic [4:0] p, input logic [12:0] d);
    chk("fetch_req", 32'(rom_req), 32'd1);
    chk("fetch_addr", 32'(rom_addr), 32'(addr));
    for (int i = 0; i < delay; i++) begin
      step();
      chk("wait_req", 32'(rom_req), 32'd1);
      chk("wait_addr", 32'(rom_addr), 32'(addr));
      chk("wait_tone", 32'(tone_en), 32'd0);
    end
    rom_ack   = 1'b1;
    rom_pitch = p;
    rom_dur   = d;
    step();
    rom_ack = 1'b0;
    chk("ack_req_low", 32'(rom_req), 32'd0);
  endtask

  task automatic checkLoad(input logic [4:0] p);
    chk("load_pulse", 32'(pitch_load), 32'd1);
    chk("load_val", 32'(pitch_maxval), 32'(p));
  endtask

  initial begin
    compared = 0; mismatched = 0; doneCount = 0;
    reset = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    rom_ack = 1'b0; rom_pitch = '0; rom_dur = '0;
    #1;
    chk("rst_req", 32'(rom_req), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tone", 32'(tone_en), 32'd0);
    chk("rst_max", 32'(pitch_maxval), 32'd0);
    step(); step();
    reset = 1'b1;
    step();

    $display("[TB] one-shot play");
    start = 1'b1; step(); start = 1'b0;
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_idx", 32'(note_idx), 32'd0);
    serveFetch(5'd0, 2, 5'd18, 13'd4);
    checkLoad(5'd18);
    chk("n0_tone", 32'(tone_en), 32'd1);
    step();
    chk("n0_load_once", 32'(pitch_load), 32'd0);
    doTick(); chk("n0_t1", 32'(tone_en), 32'd1);
    doTick(); chk("n0_t2", 32'(tone_en), 32'd1);
    doTick(); chk("n0_t3", 32'(tone_en), 32'd0);
    doTick();
    chk("n0_next_req", 32'(rom_req), 32'd1);
    chk("n0_next_idx", 32'(note_idx), 32'd1);
    serveFetch(5'd1, 2, 5'd13, 13'd2);
    checkLoad(5'd13);
    chk("n1_tone", 32'(tone_en), 32'd1);
    start = 1'b1; step(); start = 1'b0;
    chk("busy_start_req", 32'(rom_req), 32'd0);
    chk("busy_start_idx", 32'(note_idx), 32'd1);
    doTick(); chk("n1_t1", 32'(tone_en), 32'd0);
    doTick();
    chk("n1_next_addr", 32'(rom_addr), 32'd2);
    serveFetch(5'd2, 2, 5'd0, 13'd3);
    checkLoad(5'd0);
    chk("rest_tone", 32'(tone_en), 32'd0);
    doTick(); chk("rest_t1", 32'(tone_en), 32'd0);
    doTick(); chk("rest_t2", 32'(tone_en), 32'd0);
    doTick();
    chk("end_busy", 32'(busy), 32'd1);
    chk("end_req", 32'(rom_req), 32'd0);
    chk("end_done_early", 32'(done), 32'd0);
    step();
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    step();
    chk("done_once", 32'(done), 32'd0);
    chk("done_count1", 32'(doneCount), 32'd1);

    $display("[TB] loop play then stop with tick");
    loop_en = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    serveFetch(5'd0, 1, 5'd18, 13'd4); checkLoad(5'd18);
    doTick(); doTick(); doTick(); doTick();
    serveFetch(5'd1, 1, 5'd13, 13'd2); checkLoad(5'd13);
    doTick(); doTick();
    serveFetch(5'd2, 1, 5'd0, 13'd3); checkLoad(5'd0);
    doTick(); doTick(); doTick();
    chk("loop_end_req", 32'(rom_req), 32'd0);
    step();
    chk("loop_req", 32'(rom_req), 32'd1);
    chk("loop_addr", 32'(rom_addr), 32'd0);
    chk("loop_no_done", 32'(doneCount), 32'd1);
    serveFetch(5'd0, 2, 5'd18, 13'd4); checkLoad(5'd18);
    chk("loop_tone", 32'(tone_en), 32'd1);
    stop = 1'b1; tick = 1'b1; step(); stop = 1'b0; tick = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_tone", 32'(tone_en), 32'd0);
    chk("stop_req", 32'(rom_req), 32'd0);
    step();
    chk("stop_no_done", 32'(doneCount), 32'd1);
    loop_en = 1'b0;

    $display("[TB] held-off ack with ticks");
    start = 1'b1; step(); start = 1'b0;
    chk("restart_addr", 32'(rom_addr), 32'd0);
    for (int i = 0; i < 50; i++) begin
      tick = i[0];
      step();
      chk("hold_req", 32'(rom_req), 32'd1);
      chk("hold_addr", 32'(rom_addr), 32'd0);
      chk("hold_tone", 32'(tone_en), 32'd0);
    end
    tick = 1'b0;
    serveFetch(5'd0, 0, 5'd18, 13'd4); checkLoad(5'd18);
    doTick(); chk("hold_t1", 32'(tone_en), 32'd1);
    doTick(); chk("hold_t2", 32'(tone_en), 32'd1);
    doTick(); chk("hold_t3", 32'(tone_en), 32'd0);
    chk("hold_t3_noreq", 32'(rom_req), 32'd0);
    doTick();
    chk("hold_t4_req", 32'(rom_req), 32'd1);
    chk("hold_t4_addr", 32'(rom_addr), 32'd1);

    $display("[TB] async reset mid-play");
    serveFetch(5'd1, 1, 5'd13, 13'd2);
    chk("pre_rst_tone", 32'(tone_en), 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("arst_tone", 32'(tone_en), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_idx", 32'(note_idx), 32'd0);
    chk("arst_max", 32'(pitch_maxval), 32'd0);
    chk("arst_load", 32'(pitch_load), 32'd0);
    step(); step();
    reset = 1'b1;
    step();
    chk("post_rst_idle", 32'(busy), 32'd0);

    $display("[TB] end-of-song marker");
    start = 1'b1; step(); start = 1'b0;
    chk("em_req", 32'(rom_req), 32'd1);
    serveFetch(5'd0, 2, 5'd20, 13'd2); checkLoad(5'd20);
    chk("em_tone", 32'(tone_en), 32'd1);
    doTick(); chk("em_t1", 32'(tone_en), 32'd0);
    doTick();
    serveFetch(5'd1, 1, 5'd31, 13'd0);
    chk("em_no_load", 32'(pitch_load), 32'd0);
    chk("em_busy", 32'(busy), 32'd1);
    step();
    chk("em_done", 32'(done), 32'd1);
    chk("em_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("em_no_req", 32'(rom_req), 32'd0);
    end
    chk("em_done_count", 32'(doneCount), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
